// File: rtl/mtimer_pkg.sv
// Shared definitions for the machine timer: register offsets, CTRL bit
// positions, reset constants and the byte-lane write merge helper.
package mtimer_pkg;

    localparam logic [2:0] MTIME_LO_OFF    = 3'd0;
    localparam logic [2:0] MTIME_HI_OFF    = 3'd1;
    localparam logic [2:0] MTIMECMP_LO_OFF = 3'd2;
    localparam logic [2:0] MTIMECMP_HI_OFF = 3'd3;
    localparam logic [2:0] CTRL_OFF        = 3'd4;

    localparam int CTRL_CNT_EN = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [1:0]  CTRL_RST     = 2'b11;

    // Replace each byte of old_val whose enable bit is set with the byte of new_val.
    function automatic logic [31:0] be_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Divides the core clock down to mtime increment ticks; the count is held at
// zero while disabled and restarts from zero whenever software rewrites mtime.
module timer_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

    logic [PCNT_W-1:0] pcnt_reg;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pcnt_reg <= '0;
        end else if (clr_i || !en_i || (pcnt_reg == PCNT_LAST)) begin
            pcnt_reg <= '0;
        end else begin
            pcnt_reg <= pcnt_reg + PCNT_W'(1);
        end
    end

    // A clearing write to mtime takes precedence over the tick in the same cycle.
    assign tick_o = en_i & ~clr_i & (pcnt_reg == PCNT_LAST);

endmodule

// File: rtl/mtimer.sv
// RISC-V machine timer on the data-memory port: 64-bit mtime/mtimecmp with
// prescaled counting, a tear-free high-half shadow and a level timer interrupt.
module mtimer
    import mtimer_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter int ADDR_W   = 30
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              ena_i,
    input  logic              read_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [3:0]        wsel_byte_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              irq_timer_o
);

    logic [63:0] mtime_reg, mtime_next;
    logic [63:0] mtimecmp_reg, mtimecmp_next;
    logic [1:0]  ctrl_reg, ctrl_next;
    logic [31:0] hi_shadow_reg;
    logic [31:0] rdata_reg, rdata_next;
    logic        irq_reg;

    logic [2:0]  off;
    logic        wr_en, rd_en;
    logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;
    logic        tick;
    logic        unused_addr;

    assign off         = addr_i[2:0];
    assign unused_addr = ^addr_i[ADDR_W-1:3];
    assign wr_en       = ena_i & (|wsel_byte_i);
    assign rd_en       = ena_i & read_i;

    assign wr_mtime_lo = wr_en && (off == MTIME_LO_OFF);
    assign wr_mtime_hi = wr_en && (off == MTIME_HI_OFF);
    assign wr_cmp_lo   = wr_en && (off == MTIMECMP_LO_OFF);
    assign wr_cmp_hi   = wr_en && (off == MTIMECMP_HI_OFF);
    assign wr_ctrl     = wr_en && (off == CTRL_OFF);

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .en_i   (ctrl_reg[CTRL_CNT_EN]),
        .clr_i  (wr_mtime_lo | wr_mtime_hi),
        .tick_o (tick)
    );

    always_comb begin
        mtime_next = mtime_reg;
        if (wr_mtime_lo) begin
            mtime_next[31:0] = be_merge(mtime_reg[31:0], wdata_i, wsel_byte_i);
        end else if (wr_mtime_hi) begin
            mtime_next[63:32] = be_merge(mtime_reg[63:32], wdata_i, wsel_byte_i);
        end else if (tick) begin
            mtime_next = mtime_reg + 64'd1;
        end
    end

    always_comb begin
        mtimecmp_next = mtimecmp_reg;
        if (wr_cmp_lo) begin
            mtimecmp_next[31:0] = be_merge(mtimecmp_reg[31:0], wdata_i, wsel_byte_i);
        end else if (wr_cmp_hi) begin
            mtimecmp_next[63:32] = be_merge(mtimecmp_reg[63:32], wdata_i, wsel_byte_i);
        end
    end

    always_comb begin
        ctrl_next = ctrl_reg;
        if (wr_ctrl && wsel_byte_i[0]) begin
            ctrl_next = wdata_i[1:0];
        end
    end

    // Read mux sees pre-write register values, so a same-cycle write is not reflected.
    always_comb begin
        rdata_next = rdata_reg;
        if (rd_en) begin
            case (off)
                MTIME_LO_OFF:    rdata_next = mtime_reg[31:0];
                MTIME_HI_OFF:    rdata_next = hi_shadow_reg;
                MTIMECMP_LO_OFF: rdata_next = mtimecmp_reg[31:0];
                MTIMECMP_HI_OFF: rdata_next = mtimecmp_reg[63:32];
                CTRL_OFF:        rdata_next = {30'd0, ctrl_reg};
                default:         rdata_next = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mtime_reg     <= 64'd0;
            mtimecmp_reg  <= MTIMECMP_RST;
            ctrl_reg      <= CTRL_RST;
            hi_shadow_reg <= 32'd0;
            rdata_reg     <= 32'd0;
            irq_reg       <= 1'b0;
        end else begin
            mtime_reg    <= mtime_next;
            mtimecmp_reg <= mtimecmp_next;
            ctrl_reg     <= ctrl_next;
            rdata_reg    <= rdata_next;
            if (rd_en && (off == MTIME_LO_OFF)) begin
                hi_shadow_reg <= mtime_reg[63:32];
            end
            irq_reg <= ctrl_reg[CTRL_IRQ_EN] & (mtime_reg >= mtimecmp_reg);
        end
    end

    assign rdata_o     = rdata_reg;
    assign irq_timer_o = irq_reg;

endmodule
